msg_router: RTL and testbench

Byte-stream packet router between the host link (SPI/UART byte transceiver) and the per-destination register and peripheral blocks. It parses incoming packets and delivers each payload byte to exactly one destination over the shared `master_data`/`valid_bus` pair. In the return direction it polls destinations for pending messages, arbitrates round-robin, and serialises responses into packets for the link transmitter.

---
 rtl/msg_router_pkg.sv | 30 +++
 rtl/msg_router_if.sv | 42 ++++
 rtl/msg_router_rr_arbiter.sv | 62 ++++++
 rtl/msg_router.sv | 214 +++++++++++++++++++++
 tb/tb_msg_router.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msg_router_pkg
// Purpose  : Shared constants and state encodings for the msg_router slice.
//            Holds the packet SYNC byte, the default destination count and
//            the RX/TX state enums used by the router FSMs.
// Revision : 1.0 - initial release
// ============================================================================
package msg_router_pkg;

    localparam logic [7:0] c_SYNC       = 8'hAA;
    localparam int         c_DEF_N_DEST = 10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_LEN  = 2'd2,
        R_DATA = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE = 3'd0,
        T_SYNC = 3'd1,
        T_ADDR = 3'd2,
        T_LEN  = 3'd3,
        T_DATA = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/msg_router_if.sv
`default_nettype none
// ============================================================================
// Module   : msg_router_if
// Purpose  : Bundles the link-side byte streams and the destination-side
//            buses of msg_router.
//   master modport (router side):
//     in : rx_data, rx_valid, tx_ready, have_msg_bus, len_bus, slave_data_bus
//     out: tx_data, tx_valid, master_data, valid_bus, rdreq_bus, rx_err
//   slave modport: the same signals seen from the link/destination side.
// Revision : 1.0 - initial release
// ============================================================================
interface msg_router_if
    import msg_router_pkg::*;
#(
    parameter int N_DEST = c_DEF_N_DEST
) ();

    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [7:0]          master_data;
    logic [N_DEST-1:0]   valid_bus;
    logic [N_DEST-1:0]   have_msg_bus;
    logic [8*N_DEST-1:0] len_bus;
    logic [8*N_DEST-1:0] slave_data_bus;
    logic [N_DEST-1:0]   rdreq_bus;
    logic                rx_err;

    modport master (
        input  rx_data, rx_valid, tx_ready, have_msg_bus, len_bus, slave_data_bus,
        output tx_data, tx_valid, master_data, valid_bus, rdreq_bus, rx_err
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, have_msg_bus, len_bus, slave_data_bus,
        input  tx_data, tx_valid, master_data, valid_bus, rdreq_bus, rx_err
    );

endinterface
`default_nettype wire

// File: rtl/msg_router_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter. Searches req starting at the pointer,
//            returns a one-hot grant plus its index, and moves the pointer
//            to (index + 1) mod N when accept is high and a grant exists.
// Ports    : clk, n_rst (async, active-low), req[N], accept,
//            grant[N] (one-hot), idx[IW], any (some request present)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 10,
    parameter int IW = 4
) (
    input  wire logic          clk,
    input  wire logic          n_rst,
    input  wire logic [N-1:0]  req,
    input  wire logic          accept,
    output logic      [N-1:0]  grant,
    output logic      [IW-1:0] idx,
    output logic               any
);

    logic [IW-1:0] r_ptr;
    logic [N-1:0]  w_grant;
    logic [IW-1:0] w_idx;
    logic          w_any;
    logic [IW:0]   w_pos;

    // Rotating priority: candidate i is (ptr + i) mod N, first hit wins.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_any   = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (!w_any && req[w_pos[IW-1:0]]) begin
                w_any                   = 1'b1;
                w_grant[w_pos[IW-1:0]]  = 1'b1;
                w_idx                   = w_pos[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ptr <= '0;
        end else if (accept && w_any) begin
            r_ptr <= (w_idx == IW'(N-1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign grant = w_grant;
    assign idx   = w_idx;
    assign any   = w_any;

endmodule
`default_nettype wire

// File: rtl/msg_router.sv
`default_nettype none
// ============================================================================
// Module   : msg_router
// Purpose  : Byte-stream packet router. RX parses SYNC/ADDR/LEN/payload
//            packets and strobes each payload byte to one destination.
//            TX polls destinations round-robin and serialises their
//            responses into packets of the same format.
// Ports    : clk, n_rst (async, active-low), bus (msg_router_if.master)
// Params   : N_DEST destinations, TIMEOUT RX inter-byte timeout (cycles)
// Options  : MSG_ROUTER_TIMEOUT_EN - build the RX inter-byte timeout
// Revision : 1.0 - initial release
// ============================================================================
module msg_router
    import msg_router_pkg::*;
#(
    parameter int N_DEST  = c_DEF_N_DEST,
    parameter int TIMEOUT = 1000
) (
    input  wire logic   clk,
    input  wire logic   n_rst,
    msg_router_if.master bus
);

    localparam int         c_IW       = (N_DEST > 1) ? $clog2(N_DEST) : 1;
    localparam logic [8:0] c_N_DEST_9 = 9'(N_DEST);

    // ---------------------------------------------------------------- RX
    rx_state_t           r_rx_state;
    logic [7:0]          r_rx_addr;
    logic [7:0]          r_rx_cnt;
    logic                r_drop;
    logic [7:0]          r_master_data;
    logic [N_DEST-1:0]   r_valid_bus;
    logic                r_rx_err;
    logic                w_timeout;
    logic [N_DEST-1:0]   w_rx_onehot;

    assign w_rx_onehot = {{(N_DEST-1){1'b0}}, 1'b1} << r_rx_addr;

`ifdef MSG_ROUTER_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    // Counts idle cycles inside a packet; any received byte restarts it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_to_cnt <= '0;
        end else if (bus.rx_valid || (r_rx_state == R_IDLE)) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // A byte arriving in the expiry cycle still counts as on time.
    assign w_timeout = (r_rx_state != R_IDLE) && !bus.rx_valid &&
                       (r_to_cnt == c_TO_W'(TIMEOUT));
`else
    // No timeout in this build: a partial packet waits indefinitely.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_state    <= R_IDLE;
            r_rx_addr     <= '0;
            r_rx_cnt      <= '0;
            r_drop        <= 1'b0;
            r_master_data <= '0;
            r_valid_bus   <= '0;
            r_rx_err      <= 1'b0;
        end else begin
            r_valid_bus <= '0;
            r_rx_err    <= 1'b0;
            if (w_timeout) begin
                r_rx_state <= R_IDLE;
                r_rx_err   <= 1'b1;
            end else if (bus.rx_valid) begin
                case (r_rx_state)
                    R_IDLE: begin
                        if (bus.rx_data == c_SYNC) begin
                            r_rx_state <= R_ADDR;
                        end
                    end
                    R_ADDR: begin
                        r_rx_addr  <= bus.rx_data;
                        r_drop     <= ({1'b0, bus.rx_data} >= c_N_DEST_9);
                        r_rx_err   <= ({1'b0, bus.rx_data} >= c_N_DEST_9);
                        r_rx_state <= R_LEN;
                    end
                    R_LEN: begin
                        r_rx_cnt   <= bus.rx_data;
                        r_rx_state <= (bus.rx_data == 8'h00) ? R_IDLE : R_DATA;
                    end
                    R_DATA: begin
                        r_master_data <= bus.rx_data;
                        if (!r_drop) begin
                            r_valid_bus <= w_rx_onehot;
                        end
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                        if (r_rx_cnt == 8'd1) begin
                            r_rx_state <= R_IDLE;
                        end
                    end
                    default: r_rx_state <= R_IDLE;
                endcase
            end
        end
    end

    assign bus.master_data = r_master_data;
    assign bus.valid_bus   = r_valid_bus;
    assign bus.rx_err      = r_rx_err;

    // ---------------------------------------------------------------- TX
    tx_state_t           r_tx_state;
    logic [c_IW-1:0]     r_tx_idx;
    logic [N_DEST-1:0]   r_tx_grant;
    logic [7:0]          r_tx_cnt;
    logic [N_DEST-1:0]   w_arb_grant;
    logic [c_IW-1:0]     w_arb_idx;
    logic                w_arb_any;
    logic [7:0]          w_arb_len;
    logic [7:0]          w_head;
    logic [7:0]          w_tx_data;
    logic                w_tx_valid;
    logic                w_hs;

    rr_arbiter #(
        .N  (N_DEST),
        .IW (c_IW)
    ) u_arb (
        .clk    (clk),
        .n_rst  (n_rst),
        .req    (bus.have_msg_bus),
        .accept (r_tx_state == T_IDLE),
        .grant  (w_arb_grant),
        .idx    (w_arb_idx),
        .any    (w_arb_any)
    );

    // Length of the candidate being granted and head byte of the destination
    // currently being served.
    always_comb begin
        w_arb_len = '0;
        w_head    = '0;
        for (int i = 0; i < N_DEST; i++) begin
            if (w_arb_idx == c_IW'(i)) begin
                w_arb_len = bus.len_bus[8*i +: 8];
            end
            if (r_tx_idx == c_IW'(i)) begin
                w_head = bus.slave_data_bus[8*i +: 8];
            end
        end
    end

    assign w_tx_valid = (r_tx_state != T_IDLE);
    assign w_hs       = w_tx_valid && bus.tx_ready;

    // Payload bytes come straight from the show-ahead head so that a pop in
    // the handshake cycle exposes the next byte for the following cycle.
    always_comb begin
        w_tx_data = 8'h00;
        case (r_tx_state)
            T_SYNC:  w_tx_data = c_SYNC;
            T_ADDR:  w_tx_data = 8'(r_tx_idx);
            T_LEN:   w_tx_data = r_tx_cnt;
            T_DATA:  w_tx_data = w_head;
            default: w_tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_state <= T_IDLE;
            r_tx_idx   <= '0;
            r_tx_grant <= '0;
            r_tx_cnt   <= '0;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    if (w_arb_any) begin
                        r_tx_idx   <= w_arb_idx;
                        r_tx_grant <= w_arb_grant;
                        r_tx_cnt   <= w_arb_len;
                        r_tx_state <= T_SYNC;
                    end
                end
                T_SYNC: if (w_hs) r_tx_state <= T_ADDR;
                T_ADDR: if (w_hs) r_tx_state <= T_LEN;
                T_LEN: begin
                    if (w_hs) begin
                        r_tx_state <= (r_tx_cnt == 8'h00) ? T_IDLE : T_DATA;
                    end
                end
                T_DATA: begin
                    if (w_hs) begin
                        r_tx_cnt <= r_tx_cnt - 1'b1;
                        if (r_tx_cnt == 8'd1) begin
                            r_tx_state <= T_IDLE;
                        end
                    end
                end
                default: r_tx_state <= T_IDLE;
            endcase
        end
    end

    assign bus.tx_valid  = w_tx_valid;
    assign bus.tx_data   = w_tx_data;
    assign bus.rdreq_bus = ((r_tx_state == T_DATA) && w_hs) ? r_tx_grant : '0;

endmodule
`default_nettype wire

// File: tb/tb_msg_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_router
// Purpose  : Self-checking bench for msg_router. Directed RX/TX packets,
//            expected strobes and TX bytes held in scoreboard queues and
//            checked by a negedge monitor; destinations modelled as queues.
// Options  : MSG_ROUTER_TIMEOUT_EN selects the timeout expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_router;
    import msg_router_pkg::*;

    localparam int N  = 10;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic n_rst;

    msg_router_if #(.N_DEST(N)) bus ();

    msg_router #(.N_DEST(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] vb;
        logic [7:0]   d;
    } rx_exp_t;

    int          total = 0;
    int          bad   = 0;
    rx_exp_t     rx_sb[$];
    logic [7:0]  tx_sb[$];
    logic [7:0]  dq[N][$];
    logic [7:0]  dlen[N];
    int          rdreq_cnt[N];
    int          rx_err_cnt = 0;
    logic [N-1:0] pop_mask = '0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    rx_exp_t     e_rx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Destination-side inputs derived from the queue model.
    task automatic drive_dest();
        for (int i = 0; i < N; i++) begin
            bus.have_msg_bus[i]         = (dq[i].size() != 0);
            bus.len_bus[8*i +: 8]        = dlen[i];
            bus.slave_data_bus[8*i +: 8] = (dq[i].size() != 0) ? dq[i][0] : 8'h00;
        end
    endtask

    // One clock: pops requested in the previous cycle take effect after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pop_mask[i]) begin
                chk("pop_nonempty", 64'(dq[i].size() != 0), 64'd1);
                if (dq[i].size() != 0) void'(dq[i].pop_front());
            end
        end
        drive_dest();
    endtask

    task automatic send(input logic [7:0] b[$]);
        foreach (b[k]) begin
            bus.rx_data  = b[k];
            bus.rx_valid = 1'b1;
            tick();
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic exp_rx(input int d, input logic [7:0] data);
        rx_exp_t e;
        e.vb    = '0;
        e.vb[d] = 1'b1;
        e.d     = data;
        rx_sb.push_back(e);
    endtask

    task automatic load(input int d, input logic [7:0] b[$]);
        foreach (b[k]) dq[d].push_back(b[k]);
        dlen[d] = 8'(b.size());
        drive_dest();
    endtask

    task automatic exp_tx(input logic [7:0] b[$]);
        foreach (b[k]) tx_sb.push_back(b[k]);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (n_rst) begin
            pop_mask = bus.rdreq_bus;
            if (bus.rdreq_bus != '0) begin
                chk("rdreq_in_hs", {62'd0, bus.tx_valid, bus.tx_ready}, 64'd3);
                chk("rdreq_onehot", 64'($onehot(bus.rdreq_bus)), 64'd1);
                for (int i = 0; i < N; i++) if (bus.rdreq_bus[i]) rdreq_cnt[i]++;
            end
            if (bus.valid_bus != '0) begin
                if (rx_sb.size() == 0) begin
                    chk("rx_unexpected", 64'(bus.valid_bus), 64'd0);
                end else begin
                    e_rx = rx_sb.pop_front();
                    chk("rx_strobe", 64'({bus.valid_bus, bus.master_data}), 64'(e_rx));
                end
            end
            if (bus.rx_err) rx_err_cnt++;
            if (prev_stall) chk("tx_hold", {55'd0, bus.tx_valid, bus.tx_data}, {55'd0, 1'b1, prev_data});
            if (bus.tx_valid && bus.tx_ready) begin
                if (tx_sb.size() == 0) chk("tx_unexpected", {55'd0, 1'b1, bus.tx_data}, 64'd0);
                else chk("tx_byte", 64'(bus.tx_data), 64'(tx_sb.pop_front()));
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end else begin
            pop_mask   = '0;
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        n_rst        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            dlen[i]      = 8'h00;
            rdreq_cnt[i] = 0;
        end
        drive_dest();
        #2;
        chk("reset_outputs", 64'({bus.master_data, bus.valid_bus, bus.rdreq_bus,
                                   bus.tx_valid, bus.tx_data, bus.rx_err}), 64'd0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        tick();

        // Basic delivery, with junk ignored in idle.
        exp_rx(2, 8'h5A);
        send('{8'h55, 8'h13, 8'hAA, 8'h02, 8'h01, 8'h5A});
        tick(); tick();
        chk("rx_basic_done", 64'(rx_sb.size()), 64'd0);

        // Bad address: error pulse, payload dropped, next packet fine.
        base = rx_err_cnt;
        send('{8'hAA, 8'h0C, 8'h02, 8'h11, 8'h22});
        tick(); tick();
        chk("rx_err_bad_addr", 64'(rx_err_cnt - base), 64'd1);
        exp_rx(0, 8'h07);
        send('{8'hAA, 8'h00, 8'h01, 8'h07});
        tick(); tick();
        chk("rx_after_drop", 64'(rx_sb.size()), 64'd0);

        // Zero-length packet, top address, and 0xAA as payload.
        exp_rx(9, 8'h0F);
        exp_rx(4, 8'hAA);
        exp_rx(4, 8'hAA);
        send('{8'hAA, 8'h09, 8'h00, 8'hAA, 8'h09, 8'h01, 8'h0F,
               8'hAA, 8'h04, 8'h02, 8'hAA, 8'hAA});
        tick(); tick();
        chk("rx_len0_aa_data", 64'(rx_sb.size()), 64'd0);
        chk("rx_no_spurious_err", 64'(rx_err_cnt - base), 64'd1);

        // TX single destination, full throughput; len change after grant ignored.
        bus.tx_ready = 1'b1;
        exp_tx('{8'hAA, 8'h03, 8'h02, 8'hC1, 8'hC2});
        load(3, '{8'hC1, 8'hC2});
        chk("tx_valid_before_grant", 64'(bus.tx_valid), 64'd0);
        tick();
        chk("tx_valid_after_grant", {55'd0, bus.tx_valid, bus.tx_data}, {55'd0, 1'b1, 8'hAA});
        dlen[3] = 8'h07;
        drive_dest();
        repeat (5) tick();
        chk("tx_throughput", {55'd0, bus.tx_valid, 8'(tx_sb.size())}, 64'd0);
        chk("tx_rdreq3", 64'(rdreq_cnt[3]), 64'd2);
        dlen[3] = 8'h00;
        drive_dest();

        // Reset mid-packet with TX stalled and RX inside a payload.
        bus.tx_ready = 1'b0;
        load(6, '{8'h61, 8'h62, 8'h63});
        tick(); tick();
        exp_rx(2, 8'h11);
        send('{8'hAA, 8'h02, 8'h03, 8'h11});
        tick();
        n_rst = 1'b0;
        #1;
        chk("reset_mid_packet", 64'({bus.master_data, bus.valid_bus, bus.rdreq_bus,
                                      bus.tx_valid, bus.tx_data, bus.rx_err}), 64'd0);
        dq[6].delete();
        dlen[6] = 8'h00;
        drive_dest();
        tick(); tick();
        n_rst = 1'b1;
        base = rx_err_cnt;
        send('{8'h22, 8'h33});
        tick(); tick();
        chk("rx_abort_no_strobe", 64'(rx_sb.size()), 64'd0);
        chk("tx_abort_quiet", {55'd0, bus.tx_valid, 8'(rx_err_cnt - base)}, 64'd0);

        // Round robin 1 then 4, 1 re-served after 4; RX concurrently; backpressure.
        bus.tx_ready = 1'b1;
        exp_tx('{8'hAA, 8'h01, 8'h02, 8'hB1, 8'hB2,
                 8'hAA, 8'h04, 8'h01, 8'hD4,
                 8'hAA, 8'h01, 8'h01, 8'hE1});
        load(1, '{8'hB1, 8'hB2});
        load(4, '{8'hD4});
        exp_rx(7, 8'hAB);
        exp_rx(7, 8'hCD);
        send('{8'hAA, 8'h07, 8'h02, 8'hAB, 8'hCD});
        k = 0;
        while (dq[1].size() != 0 && k < 50) begin
            tick();
            k++;
        end
        chk("rr_first_done_in_time", 64'(k < 50), 64'd1);
        load(1, '{8'hE1});
        k = 0;
        while ((tx_sb.size() != 0 || bus.tx_valid) && k < 200) begin
            bus.tx_ready = ($urandom_range(0, 2) != 0);
            tick();
            k++;
        end
        bus.tx_ready = 1'b1;
        chk("rr_all_done_in_time", 64'(k < 200), 64'd1);
        chk("rr_tx_sb_empty", 64'(tx_sb.size()), 64'd0);
        chk("rr_rdreq1", 64'(rdreq_cnt[1]), 64'd3);
        chk("rr_rdreq4", 64'(rdreq_cnt[4]), 64'd1);
        chk("rx_concurrent", 64'(rx_sb.size()), 64'd0);

        // Inter-byte gap after the address.
        base = rx_err_cnt;
        send('{8'hAA, 8'h05});
        repeat (TO + 5) tick();
`ifdef MSG_ROUTER_TIMEOUT_EN
        chk("timeout_err", 64'(rx_err_cnt - base), 64'd1);
        exp_rx(5, 8'h33);
        send('{8'hAA, 8'h05, 8'h01, 8'h33});
`else
        chk("no_timeout_err", 64'(rx_err_cnt - base), 64'd0);
        exp_rx(5, 8'h33);
        send('{8'h01, 8'h33});
`endif
        tick(); tick();
        chk("gap_then_packet", 64'(rx_sb.size()), 64'd0);

        k = 0;
        for (int i = 0; i < N; i++) k += dq[i].size();
        chk("dest_queues_empty", 64'(k), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
